breakout_block_column: RTL and testbench

Parametrised column of breakable blocks for the Breakout playfield, one instance per column. It replaces the fixed single-hit, 8-row column. Each instance holds per-block health, so a block can take more than one hit. It detects ball contact on all four faces, arbitrates to one hit per ball step, applies a post-hit lockout, and keeps a saturating column score. It also drives pixel-on and pixel-health outputs to the VGA renderer.

---
 rtl/breakout_block_column.sv | 157 +++++++++++++++
 tb/tb_breakout_block_column.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_block_column.sv
// One playfield column of multi-hit blocks: four-face ball contact with
// lowest-row arbitration, post-hit lockout, saturating score and pixel lookup.
module breakout_block_column #(
  parameter int unsigned COL_X_L    = 80,
  parameter int unsigned BLOCK_W    = 16,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned ROW_Y0     = 4,
  parameter int unsigned ROW_PITCH  = 74,
  parameter int unsigned ROW_H      = 73,
  parameter int unsigned EDGE       = 3,
  parameter int unsigned EXT        = 7,
  parameter int unsigned HITS       = 2,
  parameter int unsigned POINTS     = 4,
  parameter int unsigned LOCK_TICKS = 2,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [10:0]                              pix_x,
  input  logic [10:0]                              pix_y,
  input  logic [10:0]                              ball_x_l,
  input  logic [10:0]                              ball_x_r,
  input  logic [10:0]                              ball_y_t,
  input  logic [10:0]                              ball_y_b,
  input  logic                                     ball_tick,
  output logic                                     move_u,
  output logic                                     move_d,
  output logic                                     move_l,
  output logic                                     move_r,
  output logic                                     hit_valid,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] hit_row,
  output logic                                     col_on,
  output logic [1:0]                               pix_health,
  output logic [SCORE_W-1:0]                       score,
  output logic                                     col_clear
);

  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned LW  = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;
  localparam int unsigned X_R = COL_X_L + BLOCK_W - 1;

  typedef enum logic {ARMED, LOCKOUT} state_t;

  state_t                  state_q;
  logic [LW-1:0]           lock_q;
  logic [ROWS-1:0][1:0]    health_q;
  logic [SCORE_W-1:0]      score_q;
  logic [RW-1:0]           hit_row_q;
  logic [3:0]              move_q;      // {u, d, l, r}
  logic                    hit_valid_q;
  logic                    col_clear_q;

  logic                    found_c;
  logic [RW-1:0]           win_c;
  logic [3:0]              face_c;
  logic [3:0]              f_c;
  logic [10:0]             top_c;
  logic [10:0]             bot_c;
  logic [32:0]             sum_c;
  logic [SCORE_W-1:0]      score_d;

  // Per-row face tests; the lowest-index live row with any face wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    face_c  = '0;
    f_c     = '0;
    top_c   = '0;
    bot_c   = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      top_c  = 11'(ROW_Y0 + r * ROW_PITCH);
      bot_c  = 11'(ROW_Y0 + r * ROW_PITCH + ROW_H - 1);
      f_c[0] = (ball_x_l >= 11'(X_R - EDGE)) && (ball_x_l <= 11'(X_R)) &&
               (ball_y_b >= top_c) && (ball_y_t <= bot_c);
      f_c[1] = (ball_x_r >= 11'(COL_X_L)) && (ball_x_r <= 11'(COL_X_L + EDGE)) &&
               (ball_y_b >= top_c) && (ball_y_t <= bot_c);
      f_c[2] = (ball_y_t >= 11'(ROW_Y0 + r * ROW_PITCH + ROW_H - 1 - EDGE)) &&
               (ball_y_t <= bot_c) &&
               (ball_x_l >= 11'(COL_X_L - EXT)) && (ball_x_r <= 11'(X_R + EXT));
      f_c[3] = (ball_y_b >= top_c) && (ball_y_b <= 11'(ROW_Y0 + r * ROW_PITCH + EDGE)) &&
               (ball_x_l >= 11'(COL_X_L - EXT)) && (ball_x_r <= 11'(X_R + EXT));
      if (!found_c && (health_q[r] != 2'd0) && (f_c != 4'd0)) begin
        found_c = 1'b1;
        win_c   = RW'(r);
        face_c  = f_c;
      end
    end
  end

  // Saturating score after destroying one block.
  always_comb begin
    sum_c = 33'(score_q) + 33'(POINTS);
    if (sum_c > 33'({SCORE_W{1'b1}})) score_d = {SCORE_W{1'b1}};
    else                              score_d = SCORE_W'(sum_c);
  end

  // Renderer lookup against the current registered health.
  always_comb begin
    pix_health = 2'd0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if ((pix_x >= 11'(COL_X_L)) && (pix_x <= 11'(X_R)) &&
          (pix_y >= 11'(ROW_Y0 + r * ROW_PITCH)) &&
          (pix_y <= 11'(ROW_Y0 + r * ROW_PITCH + ROW_H - 1)))
        pix_health = health_q[r];
    end
    col_on = (pix_health != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARMED;
      lock_q      <= '0;
      health_q    <= {ROWS{2'(HITS)}};
      score_q     <= '0;
      hit_row_q   <= '0;
      move_q      <= '0;
      hit_valid_q <= 1'b0;
      col_clear_q <= 1'b0;
    end else begin
      move_q      <= '0;
      hit_valid_q <= 1'b0;
      col_clear_q <= (health_q == '0);
      if (ball_tick) begin
        case (state_q)
          ARMED: begin
            if (found_c) begin
              move_q          <= {face_c[3], face_c[2], face_c[1], face_c[0]};
              hit_valid_q     <= 1'b1;
              hit_row_q       <= win_c;
              health_q[win_c] <= health_q[win_c] - 2'd1;
              if (health_q[win_c] == 2'd1) score_q <= score_d;
              if (LOCK_TICKS != 0) begin
                state_q <= LOCKOUT;
                lock_q  <= LW'(LOCK_TICKS);
              end
            end
          end
          LOCKOUT: begin
            if (lock_q == LW'(1)) state_q <= ARMED;
            lock_q <= lock_q - LW'(1);
          end
          default: state_q <= ARMED;
        endcase
      end
    end
  end

  assign move_u    = move_q[3];
  assign move_d    = move_q[2];
  assign move_l    = move_q[1];
  assign move_r    = move_q[0];
  assign hit_valid = hit_valid_q;
  assign hit_row   = hit_row_q;
  assign score     = score_q;
  assign col_clear = col_clear_q;

endmodule

// File: tb/tb_breakout_block_column.sv
// Bench for breakout_block_column: three instances (default, no lockout,
// no lockout with 5-bit score) share stimulus and are checked against a model.
module tb_breakout_block_column;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] pix_x = '0, pix_y = '0;
  logic [10:0] ball_x_l = '0, ball_x_r = '0, ball_y_t = '0, ball_y_b = '0;
  logic        ball_tick = 1'b0;

  logic       mu [3], md [3], ml [3], mr [3], hv [3], con [3], cc [3];
  logic [2:0] hr [3];
  logic [1:0] ph [3];
  logic [7:0] sc0, sc1;
  logic [4:0] sc2;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  breakout_block_column u0 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_tick(ball_tick), .move_u(mu[0]), .move_d(md[0]), .move_l(ml[0]), .move_r(mr[0]),
    .hit_valid(hv[0]), .hit_row(hr[0]), .col_on(con[0]), .pix_health(ph[0]),
    .score(sc0), .col_clear(cc[0]));

  breakout_block_column #(.LOCK_TICKS(0)) u1 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_tick(ball_tick), .move_u(mu[1]), .move_d(md[1]), .move_l(ml[1]), .move_r(mr[1]),
    .hit_valid(hv[1]), .hit_row(hr[1]), .col_on(con[1]), .pix_health(ph[1]),
    .score(sc1), .col_clear(cc[1]));

  breakout_block_column #(.LOCK_TICKS(0), .SCORE_W(5)) u2 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_tick(ball_tick), .move_u(mu[2]), .move_d(md[2]), .move_l(ml[2]), .move_r(mr[2]),
    .hit_valid(hv[2]), .hit_row(hr[2]), .col_on(con[2]), .pix_health(ph[2]),
    .score(sc2), .col_clear(cc[2]));

  // Reference model: geometry of the column, per-instance health/score/lockout.
  localparam int LK [3]   = '{2, 0, 0};
  localparam int SMAX [3] = '{255, 255, 31};
  int mh [3][8];
  int msc [3];
  int mlk [3];
  int mhr [3];
  int ef [3];
  int ehv [3];
  int pclr [3];

  function automatic int row_top(int r);
    return 4 + r * 74;
  endfunction

  function automatic int faces(int r);
    int top = row_top(r);
    int bot = top + 72;
    int bxl = int'(ball_x_l), bxr = int'(ball_x_r);
    int byt = int'(ball_y_t), byb = int'(ball_y_b);
    bit vy = (byb >= top) && (byt <= bot);
    bit hx = (bxl >= 80 - 7) && (bxr <= 95 + 7);
    bit fr = (bxl >= 95 - 3) && (bxl <= 95) && vy;
    bit fl = (bxr >= 80) && (bxr <= 80 + 3) && vy;
    bit fd = (byt >= bot - 3) && (byt <= bot) && hx;
    bit fu = (byb >= top) && (byb <= top + 3) && hx;
    return {fu, fd, fl, fr};
  endfunction

  function automatic int all_dead(int i);
    for (int r = 0; r < 8; r++) if (mh[i][r] != 0) return 0;
    return 1;
  endfunction

  function automatic int model_pix(int i);
    int x = int'(pix_x), y = int'(pix_y);
    for (int r = 0; r < 8; r++)
      if (x >= 80 && x <= 95 && y >= row_top(r) && y <= row_top(r) + 72) return mh[i][r];
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 8; r++) mh[i][r] = 2;
      msc[i] = 0; mlk[i] = 0; mhr[i] = 0;
    end
  endtask

  task automatic model_tick(int i);
    ef[i] = 0; ehv[i] = 0;
    if (mlk[i] > 0) begin
      mlk[i]--;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (mh[i][r] > 0 && faces(r) != 0) begin
          ef[i] = faces(r); ehv[i] = 1; mhr[i] = r;
          mh[i][r]--;
          if (mh[i][r] == 0) msc[i] = (msc[i] + 4 > SMAX[i]) ? SMAX[i] : msc[i] + 4;
          mlk[i] = LK[i];
          break;
        end
      end
    end
  endtask

  function automatic int get_score(int i);
    if (i == 0) return int'(sc0);
    if (i == 1) return int'(sc1);
    return int'(sc2);
  endfunction

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, expv);
    end
  endtask

  task automatic check_pix(input int x, input int y);
    pix_x = 11'(x); pix_y = 11'(y);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("pix_health", i, 32'(ph[i]), 32'(model_pix(i)));
      chk("col_on", i, 32'(con[i]), 32'(model_pix(i) != 0));
    end
  endtask

  task automatic do_reset(input bit with_tick);
    ball_tick = with_tick;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ball_tick = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_moves", i, 32'({mu[i], md[i], ml[i], mr[i]}), 32'd0);
      chk("rst_hv", i, 32'(hv[i]), 32'd0);
      chk("rst_row", i, 32'(hr[i]), 32'd0);
      chk("rst_score", i, 32'(get_score(i)), 32'd0);
      chk("rst_clear", i, 32'(cc[i]), 32'd0);
    end
  endtask

  task automatic do_tick(input int xl, input int w, input int yt, input int h, input bit idle);
    ball_x_l = 11'(xl); ball_x_r = 11'(xl + w);
    ball_y_t = 11'(yt); ball_y_b = 11'(yt + h);
    ball_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pclr[i] = all_dead(i);
      model_tick(i);
    end
    @(posedge clk); #1;
    ball_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("moves", i, 32'({mu[i], md[i], ml[i], mr[i]}), 32'(ef[i]));
      chk("hit_valid", i, 32'(hv[i]), 32'(ehv[i]));
      chk("hit_row", i, 32'(hr[i]), 32'(mhr[i]));
      chk("score", i, 32'(get_score(i)), 32'(msc[i]));
      chk("col_clear", i, 32'(cc[i]), 32'(pclr[i]));
    end
    if (idle) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk("pulse_end", i, 32'({mu[i], md[i], ml[i], mr[i], hv[i]}), 32'd0);
        chk("clear_lat", i, 32'(cc[i]), 32'(all_dead(i)));
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset(1'b0);

    // Pixel lookup at reset: inside row 0, in the row gap, left of column.
    check_pix(85, 40);
    chk("pix_row0_const", 0, 32'(ph[0]), 32'd2);
    check_pix(85, 77);
    chk("pix_gap_const", 0, 32'(con[0]), 32'd0);
    check_pix(79, 40);

    // Right-face hit on row 1, then three more ticks through the lockout.
    do_tick(94, 7, 100, 7, 1'b0);
    chk("first_mr_const", 0, 32'(mr[0]), 32'd1);
    chk("first_row_const", 0, 32'(hr[0]), 32'd1);
    @(posedge clk); #1;
    check_pix(85, 100);
    chk("row1_h1_const", 0, 32'(ph[0]), 32'd1);
    for (int k = 0; k < 3; k++) do_tick(94, 7, 100, 7, 1'b1);
    check_pix(85, 100);
    chk("row1_dead_const", 0, 32'(con[0]), 32'd0);
    chk("score4_const", 0, 32'(sc0), 32'd4);

    // Bottom face of row 0 beats top face of row 1.
    do_reset(1'b0);
    do_tick(84, 7, 74, 5, 1'b0);
    chk("bottom_md_const", 0, 32'({mu[0], md[0], ml[0], mr[0]}), 32'b0100);
    chk("bottom_row_const", 0, 32'(hr[0]), 32'd0);
    @(posedge clk); #1;
    check_pix(85, 100);
    chk("row1_untouched_const", 0, 32'(ph[0]), 32'd2);

    // Clear every row twice; the no-lockout instances empty the column.
    do_reset(1'b0);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 2; k++) do_tick(94, 7, row_top(r) + 20, 7, 1'b1);
    chk("clear_const", 1, 32'(cc[1]), 32'd1);
    chk("score32_const", 1, 32'(sc1), 32'd32);
    chk("score_sat_const", 2, 32'(sc2), 32'd31);
    check_pix(85, 40);

    // Reset during lockout (with a tick) restores health; next hit is immediate.
    do_reset(1'b0);
    do_tick(94, 7, 100, 7, 1'b1);
    ball_x_l = 11'd94; ball_x_r = 11'd101; ball_y_t = 11'd100; ball_y_b = 11'd107;
    do_reset(1'b1);
    for (int r = 0; r < 8; r++) check_pix(88, row_top(r) + 30);
    do_tick(94, 7, 100, 7, 1'b0);
    chk("relock_hv_const", 0, 32'(hv[0]), 32'd1);
    @(posedge clk); #1;

    // Randomized ball positions around the column, with back-to-back ticks.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 60) == 0) do_reset(1'b0);
      do_tick(int'($urandom_range(66, 104)), int'($urandom_range(1, 9)),
              int'($urandom_range(0, 600)), int'($urandom_range(1, 9)),
              $urandom_range(0, 2) != 0);
      if (n % 5 == 0) check_pix(int'($urandom_range(76, 99)), int'($urandom_range(0, 600)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
